// File: rtl/nano_dbg_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nano_dbg_spi_slave
// Purpose  : Oversampled SPI (mode 0) debug slave. Decodes command/address/
//            data frames into NanoController IMEM/DMEM write and read strobes
//            and controls the core reset request.
// Revision : 1.0 - initial release
// ============================================================================
module nano_dbg_spi_slave #(
  parameter int NANO_I_W_C     = 4,
  parameter int NANO_I_ADR_W_C = 9,
  parameter int NANO_D_W_C     = 9,
  parameter int NANO_D_ADR_W_C = 4
) (
  input  logic                      i_nano_clk,
  input  logic                      i_nano_rst_n,
  input  logic                      i_dbg_spi_en_n,
  input  logic                      i_dbg_spi_sclk,
  input  logic                      i_dbg_spi_mosi,
  output logic                      o_dbg_spi_miso,
  output logic [NANO_I_ADR_W_C-1:0] o_imem_addr,
  output logic [NANO_I_W_C-1:0]     o_imem_wdata,
  output logic                      o_imem_we,
  output logic                      o_imem_re,
  input  logic [NANO_I_W_C-1:0]     i_imem_rdata,
  output logic [NANO_D_ADR_W_C-1:0] o_dmem_addr,
  output logic [NANO_D_W_C-1:0]     o_dmem_wdata,
  output logic                      o_dmem_we,
  output logic                      o_dmem_re,
  input  logic [NANO_D_W_C-1:0]     i_dmem_rdata,
  output logic                      o_core_rst_n
);

  // Shared address register covers the wider of the two memories; the
  // narrower one simply uses its low bits, so increments wrap correctly.
  localparam int c_ADR_W  = (NANO_I_ADR_W_C > NANO_D_ADR_W_C) ? NANO_I_ADR_W_C : NANO_D_ADR_W_C;
  localparam int c_W_MAX  = (NANO_I_W_C > NANO_D_W_C) ? NANO_I_W_C : NANO_D_W_C;
  localparam int c_SR_W0  = (c_W_MAX > c_ADR_W) ? c_W_MAX : c_ADR_W;
  // Receive shift register only keeps the bits that are ever consumed.
  localparam int c_SR_W   = (c_SR_W0 > 8) ? c_SR_W0 : 8;

  localparam logic [c_ADR_W-1:0] c_ADR_ONE = 1;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_CMD    = 3'd1;
  localparam logic [2:0] c_ST_ADDR   = 3'd2;
  localparam logic [2:0] c_ST_DATA   = 3'd3;
  localparam logic [2:0] c_ST_IGNORE = 3'd4;

  localparam logic [7:0] c_CMD_IWR  = 8'h01;
  localparam logic [7:0] c_CMD_IRD  = 8'h02;
  localparam logic [7:0] c_CMD_DWR  = 8'h03;
  localparam logic [7:0] c_CMD_DRD  = 8'h04;
  localparam logic [7:0] c_CMD_RSTA = 8'h05;
  localparam logic [7:0] c_CMD_RSTR = 8'h06;

  logic                r_en_s1, r_en_s2;
  logic                r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic                r_mosi_s1, r_mosi_s2;
  logic [2:0]          r_state, w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_last_idx;
  logic [c_SR_W-1:0]   r_shift, w_shift_next;
  logic [c_ADR_W-1:0]  r_addr;
  logic [15:0]         r_tx, w_rdata_ext;
  logic                r_bit_last, r_re, r_rd_cap;
  logic                r_is_imem, r_is_read, r_core_rst_n;
  logic                w_active, w_rise, w_fall, w_in_frame, w_sample;
  logic                w_last_bit, w_word_done, w_we;

  assign w_active     = ~r_en_s2;
  assign w_rise       = w_active &  r_sclk_s2 & ~r_sclk_d;
  assign w_fall       = w_active & ~r_sclk_s2 &  r_sclk_d;
  assign w_in_frame   = (r_state == c_ST_CMD) | (r_state == c_ST_ADDR) | (r_state == c_ST_DATA);
  assign w_sample     = w_rise & w_in_frame;
  assign w_last_idx   = (r_state == c_ST_CMD) ? 4'd7 : 4'd15;
  assign w_last_bit   = w_sample & (r_cnt == w_last_idx);
  assign w_word_done  = r_bit_last & w_active;
  assign w_shift_next = {r_shift[c_SR_W-2:0], r_mosi_s2};
  assign w_rdata_ext  = r_is_imem ? 16'(i_imem_rdata) : 16'(i_dmem_rdata);

  assign o_imem_addr  = r_addr[NANO_I_ADR_W_C-1:0];
  assign o_dmem_addr  = r_addr[NANO_D_ADR_W_C-1:0];
  assign o_imem_wdata = r_shift[NANO_I_W_C-1:0];
  assign o_dmem_wdata = r_shift[NANO_D_W_C-1:0];
  assign o_core_rst_n = r_core_rst_n;

  // Two-flop synchronisers for the SPI pins plus the SCLK edge-detect delay
  always_ff @(posedge i_nano_clk or negedge i_nano_rst_n) begin
    if (!i_nano_rst_n) begin
      r_en_s1   <= 1'b1;
      r_en_s2   <= 1'b1;
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_en_s1   <= i_dbg_spi_en_n;
      r_en_s2   <= r_en_s1;
      r_sclk_s1 <= i_dbg_spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= i_dbg_spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // Frame state register
  always_ff @(posedge i_nano_clk or negedge i_nano_rst_n) begin
    if (!i_nano_rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: chip-select release always wins, words advance on completion
  always_comb begin
    w_next = r_state;
    if (!w_active) begin
      w_next = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE: w_next = c_ST_CMD;
        c_ST_CMD: begin
          if (r_bit_last) begin
            case (r_shift[7:0])
              c_CMD_IWR, c_CMD_IRD, c_CMD_DWR, c_CMD_DRD: w_next = c_ST_ADDR;
              default:                                    w_next = c_ST_IGNORE;
            endcase
          end
        end
        c_ST_ADDR:   if (r_bit_last) w_next = c_ST_DATA;
        c_ST_DATA:   w_next = c_ST_DATA;
        c_ST_IGNORE: w_next = c_ST_IGNORE;
        default:     w_next = c_ST_IDLE;
      endcase
    end
  end

  // Output decode: memory strobes and MISO, never IMEM and DMEM together
  always_comb begin
    w_we           = (r_state == c_ST_DATA) & w_word_done & ~r_is_read;
    o_imem_we      = w_we &  r_is_imem;
    o_dmem_we      = w_we & ~r_is_imem;
    o_imem_re      = r_re &  r_is_imem;
    o_dmem_re      = r_re & ~r_is_imem;
    o_dbg_spi_miso = (r_state == c_ST_DATA) & r_is_read & r_tx[15];
  end

  // Datapath: bit counting, shifting, address, read pipeline and core reset
  always_ff @(posedge i_nano_clk or negedge i_nano_rst_n) begin
    if (!i_nano_rst_n) begin
      r_cnt        <= 4'd0;
      r_shift      <= '0;
      r_addr       <= '0;
      r_tx         <= 16'd0;
      r_bit_last   <= 1'b0;
      r_re         <= 1'b0;
      r_rd_cap     <= 1'b0;
      r_is_imem    <= 1'b0;
      r_is_read    <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_bit_last <= w_last_bit;
      r_re       <= 1'b0;
      r_rd_cap   <= r_re;

      if (w_next != r_state) begin
        r_cnt <= 4'd0;
      end else if (w_sample) begin
        r_cnt <= r_cnt + 4'd1;
      end

      if (w_sample) begin
        r_shift <= w_shift_next;
      end

      // Address is taken straight from the last sampled bit so the first
      // read strobe can fire in the very next cycle.
      if (w_last_bit && (r_state == c_ST_ADDR)) begin
        r_addr <= w_shift_next[c_ADR_W-1:0];
        r_re   <= r_is_read;
      end

      if ((r_state == c_ST_CMD) && w_word_done) begin
        r_is_imem <= (r_shift[7:0] == c_CMD_IWR) | (r_shift[7:0] == c_CMD_IRD);
        r_is_read <= (r_shift[7:0] == c_CMD_IRD) | (r_shift[7:0] == c_CMD_DRD);
        if (r_shift[7:0] == c_CMD_RSTA) r_core_rst_n <= 1'b0;
        if (r_shift[7:0] == c_CMD_RSTR) r_core_rst_n <= 1'b1;
      end

      // Write strobe is issued this cycle at the old address; a read
      // strobe follows one cycle later at the new address.
      if ((r_state == c_ST_DATA) && w_word_done) begin
        r_addr <= r_addr + c_ADR_ONE;
        r_re   <= r_is_read;
      end

      // Counter zero marks the preloaded MSB, which must not be shifted away
      if (r_rd_cap) begin
        r_tx <= w_rdata_ext;
      end else if (w_fall && (r_state == c_ST_DATA) && r_is_read && (r_cnt != 4'd0)) begin
        r_tx <= {r_tx[14:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nano_dbg_spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nano_dbg_spi_slave
// Purpose  : Directed self-checking bench for nano_dbg_spi_slave; acts as
//            the SPI debug master and a simple DMEM read responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nano_dbg_spi_slave;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en_n   = 1'b1;
  logic       sclk   = 1'b0;
  logic       mosi   = 1'b0;
  logic       miso;
  logic [8:0] imem_addr;
  logic [3:0] imem_wdata;
  logic       imem_we, imem_re;
  logic [3:0] imem_rdata = 4'h0;
  logic [3:0] dmem_addr;
  logic [8:0] dmem_wdata;
  logic       dmem_we, dmem_re;
  logic [8:0] dmem_rdata = 9'h000;
  logic       core_rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] iwe_addr_q[$];
  logic [3:0] iwe_data_q[$];
  logic [3:0] dwe_addr_q[$];
  logic [8:0] dwe_data_q[$];
  logic [3:0] dre_addr_q[$];
  int         ire_cnt  = 0;
  int         miso_ones = 0;
  int         both_cnt = 0;

  nano_dbg_spi_slave #(
    .NANO_I_W_C(4), .NANO_I_ADR_W_C(9), .NANO_D_W_C(9), .NANO_D_ADR_W_C(4)
  ) dut (
    .i_nano_clk    (clk),
    .i_nano_rst_n  (rst_n),
    .i_dbg_spi_en_n(en_n),
    .i_dbg_spi_sclk(sclk),
    .i_dbg_spi_mosi(mosi),
    .o_dbg_spi_miso(miso),
    .o_imem_addr   (imem_addr),
    .o_imem_wdata  (imem_wdata),
    .o_imem_we     (imem_we),
    .o_imem_re     (imem_re),
    .i_imem_rdata  (imem_rdata),
    .o_dmem_addr   (dmem_addr),
    .o_dmem_wdata  (dmem_wdata),
    .o_dmem_we     (dmem_we),
    .o_dmem_re     (dmem_re),
    .i_dmem_rdata  (dmem_rdata),
    .o_core_rst_n  (core_rst_n)
  );

  always #5 clk = ~clk;

  // DMEM responder: data valid one cycle after the read strobe
  always @(posedge clk) begin
    if (dmem_re) dmem_rdata <= (dmem_addr == 4'd7) ? 9'h1A5 : (dmem_addr == 4'd8) ? 9'h0FF : 9'h000;
  end

  // Strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we) begin iwe_addr_q.push_back(imem_addr); iwe_data_q.push_back(imem_wdata); end
    if (dmem_we) begin dwe_addr_q.push_back(dmem_addr); dwe_data_q.push_back(dmem_wdata); end
    if (dmem_re) dre_addr_q.push_back(dmem_addr);
    if (imem_re) ire_cnt++;
    if (miso) miso_ones++;
    if ((imem_we | imem_re) & (dmem_we | dmem_re)) both_cnt++;
  end

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    repeat (6) @(negedge clk);
    m = miso;
    sclk = 1'b1;
    repeat (6) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic spi_bits(input logic [15:0] v, input int n, output logic [15:0] rx);
    logic m;
    rx = 16'h0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(v[i], m);
      rx = {rx[14:0], m};
    end
  endtask

  task automatic frame_begin();
    en_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (6) @(negedge clk);
    en_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic cmd_frame(input logic [7:0] cmd);
    logic [15:0] rx;
    frame_begin();
    spi_bits({8'h00, cmd}, 8, rx);
    frame_end();
  endtask

  initial begin
    logic [15:0] rx;
    int base_i, base_d, base_r, base_m, base_ire;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_miso",       32'(miso),       32'd0);
    check("rst_strobes",    32'({imem_we, imem_re, dmem_we, dmem_re}), 32'd0);
    check("rst_addr",       32'({imem_addr, dmem_addr}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rel_core_rst_n", 32'(core_rst_n), 32'd0);

    // Core reset release / assert / release
    frame_begin();
    spi_bits(16'h0006, 8, rx);
    check("cmd06_core_rst_n", 32'(core_rst_n), 32'd1);
    frame_end();
    cmd_frame(8'h05);
    check("cmd05_core_rst_n", 32'(core_rst_n), 32'd0);
    cmd_frame(8'h06);
    check("cmd06b_core_rst_n", 32'(core_rst_n), 32'd1);

    // IMEM write burst with address wrap
    base_i = iwe_addr_q.size();
    base_d = dwe_addr_q.size();
    frame_begin();
    spi_bits(16'h0001, 8, rx);
    spi_bits(16'h01FE, 16, rx);
    spi_bits(16'h000A, 16, rx);
    spi_bits(16'h0005, 16, rx);
    spi_bits(16'h0003, 16, rx);
    frame_end();
    check("iwr_count", 32'(iwe_addr_q.size() - base_i), 32'd3);
    if (iwe_addr_q.size() >= base_i + 3) begin
      check("iwr0_addr", 32'(iwe_addr_q[base_i]),     32'h1FE);
      check("iwr0_data", 32'(iwe_data_q[base_i]),     32'hA);
      check("iwr1_addr", 32'(iwe_addr_q[base_i + 1]), 32'h1FF);
      check("iwr1_data", 32'(iwe_data_q[base_i + 1]), 32'h5);
      check("iwr2_addr", 32'(iwe_addr_q[base_i + 2]), 32'h000);
      check("iwr2_data", 32'(iwe_data_q[base_i + 2]), 32'h3);
    end
    check("iwr_no_dmem_we", 32'(dwe_addr_q.size() - base_d), 32'd0);

    // DMEM read burst
    base_r   = dre_addr_q.size();
    base_ire = ire_cnt;
    frame_begin();
    spi_bits(16'h0004, 8, rx);
    spi_bits(16'h0007, 16, rx);
    spi_bits(16'h0000, 16, rx);
    check("drd_word0", 32'(rx), 32'h01A5);
    spi_bits(16'h0000, 16, rx);
    check("drd_word1", 32'(rx), 32'h00FF);
    frame_end();
    check("drd_re_count_ge2", 32'(dre_addr_q.size() - base_r >= 2), 32'd1);
    if (dre_addr_q.size() >= base_r + 2) begin
      check("drd_re0_addr", 32'(dre_addr_q[base_r]),     32'd7);
      check("drd_re1_addr", 32'(dre_addr_q[base_r + 1]), 32'd8);
    end
    check("drd_no_imem_re", 32'(ire_cnt - base_ire), 32'd0);

    // Abort mid-word, then a normal DMEM write
    base_d = dwe_addr_q.size();
    frame_begin();
    spi_bits(16'h0003, 8, rx);
    spi_bits(16'h0002, 16, rx);
    spi_bits(16'h01FF, 9, rx);
    frame_end();
    check("abort_no_dmem_we", 32'(dwe_addr_q.size() - base_d), 32'd0);
    frame_begin();
    spi_bits(16'h0003, 8, rx);
    spi_bits(16'h0005, 16, rx);
    spi_bits(16'hFFFF, 16, rx);
    frame_end();
    check("dwr_count", 32'(dwe_addr_q.size() - base_d), 32'd1);
    if (dwe_addr_q.size() >= base_d + 1) begin
      check("dwr_addr", 32'(dwe_addr_q[base_d]), 32'd5);
      check("dwr_data", 32'(dwe_data_q[base_d]), 32'h1FF);
    end

    // Unknown command: no strobes, MISO idle, core reset untouched
    base_i = iwe_addr_q.size();
    base_d = dwe_addr_q.size();
    base_r = dre_addr_q.size();
    base_ire = ire_cnt;
    base_m = miso_ones;
    frame_begin();
    spi_bits(16'h007E, 8, rx);
    spi_bits(16'hFFFF, 16, rx);
    spi_bits(16'hFFFF, 16, rx);
    frame_end();
    check("unk_strobes", 32'((iwe_addr_q.size() - base_i) + (dwe_addr_q.size() - base_d)
                             + (dre_addr_q.size() - base_r) + (ire_cnt - base_ire)), 32'd0);
    check("unk_miso", 32'(miso_ones - base_m), 32'd0);
    check("unk_core_rst_n", 32'(core_rst_n), 32'd1);

    // Asynchronous reset in the middle of a data word
    frame_begin();
    spi_bits(16'h0001, 8, rx);
    spi_bits(16'h0033, 16, rx);
    spi_bits(16'h00FF, 8, rx);
    check("pre_rst_addr", 32'(imem_addr), 32'h033);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("arst_addr",       32'({imem_addr, dmem_addr}), 32'd0);
    check("arst_wdata",      32'({imem_wdata, dmem_wdata}), 32'd0);
    check("arst_strobes_miso", 32'({imem_we, imem_re, dmem_we, dmem_re, miso}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en_n  = 1'b1;
    repeat (10) @(negedge clk);

    // New frames after reset are accepted from IDLE
    cmd_frame(8'h06);
    check("post_rst_core_rst_n", 32'(core_rst_n), 32'd1);
    base_i = iwe_addr_q.size();
    frame_begin();
    spi_bits(16'h0001, 8, rx);
    spi_bits(16'h0010, 16, rx);
    spi_bits(16'h000C, 16, rx);
    frame_end();
    check("post_rst_iwr_count", 32'(iwe_addr_q.size() - base_i), 32'd1);
    if (iwe_addr_q.size() >= base_i + 1) begin
      check("post_rst_iwr_addr", 32'(iwe_addr_q[base_i]), 32'h010);
      check("post_rst_iwr_data", 32'(iwe_data_q[base_i]), 32'hC);
    end

    check("never_both_mems", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nano_dbg_spi_slave.md
Name: nano_dbg_spi_slave

Overview:
- SPI debug slave inside the DUT, directly downstream of the testbench SPI debug master: consumes the master's i_dbg_spi_* frames and drives o_dbg_spi_miso back to it.
- Decodes command/address/data frames into NanoController IMEM/DMEM write and read strobes (program load, readback), and controls the core's internal reset.
- Fully synchronous to the NanoController clock. SPI inputs are oversampled; there is no SCLK clock domain.

Parameters:
NANO_I_W_C, 4, instruction word width
NANO_I_ADR_W_C, 9, IMEM address width
NANO_D_W_C, 9, data word width
NANO_D_ADR_W_C, 4, DMEM address width

Ports:
i_nano_clk  in  1  system clock; all state changes on its rising edge
i_nano_rst_n  in  1  asynchronous active-low reset
i_dbg_spi_en_n  in  1  SPI chip select, active low
i_dbg_spi_sclk  in  1  SPI clock, mode 0
i_dbg_spi_mosi  in  1  SPI data in, MSB first
o_dbg_spi_miso  out  1  SPI data out
o_imem_addr  out  NANO_I_ADR_W_C  IMEM address
o_imem_wdata  out  NANO_I_W_C  IMEM write data
o_imem_we  out  1  IMEM write strobe, 1-cycle pulse
o_imem_re  out  1  IMEM read strobe, 1-cycle pulse
i_imem_rdata  in  NANO_I_W_C  IMEM read data, valid 1 cycle after o_imem_re
o_dmem_addr  out  NANO_D_ADR_W_C  DMEM address
o_dmem_wdata  out  NANO_D_W_C  DMEM write data
o_dmem_we  out  1  DMEM write strobe
o_dmem_re  out  1  DMEM read strobe
i_dmem_rdata  in  NANO_D_W_C  DMEM read data, valid 1 cycle after o_dmem_re
o_core_rst_n  out  1  core reset request, active low

Behaviour:
- Reset values: all outputs 0, including o_core_rst_n = 0, so the core is held in reset until released. Sync registers reset to en_n=1, sclk=0, mosi=0. FSM resets to IDLE.
- Input sync: en_n, sclk and mosi each pass through 2 flip-flops. SCLK edges are detected on the synced value (rise = sample MOSI; fall = shift MISO).
- SCLK timing requirement: each SCLK high and low phase lasts at least 4 i_nano_clk cycles.
- Frame format: 8-bit command, then 16-bit address (low ADR_W bits used), then any number of 16-bit data words (low W bits used, upper bits ignored on write, zero on read).
- FSM states: IDLE -> CMD on synced en_n falling.
  - CMD -> ADDR after 8 bits for 0x01 IMEM write, 0x02 IMEM read, 0x03 DMEM write, 0x04 DMEM read.
  - 0x05 sets o_core_rst_n=0 and 0x06 sets it to 1, in the cycle after the 8th bit, then -> IGNORE.
  - Any other command -> IGNORE.
  - ADDR -> DATA after 16 bits.
  - DATA stays in DATA.
  - Synced en_n high from any state -> IDLE next cycle.
- Bit counter: resets to 0 on every state entry and wraps per word.
- Write: in the cycle after the 16th data bit is sampled, wdata = shift register low bits and we = 1 for exactly 1 cycle at the current address. The address increments the following cycle, wrapping modulo 2^ADR_W.
- Read:
  - In the cycle after the last address bit, re = 1 for 1 cycle.
  - Rdata is captured 1 cycle later into a 16-bit tx register, zero-extended.
  - After each 16th data bit: address increments, re pulses, tx reloads with the same 2-cycle latency.
- MISO: o_dbg_spi_miso = tx[15] in a read DATA state, else 0. tx shifts left on an SCLK fall only when the bit counter is nonzero, so the preloaded MSB is never skipped.
- en_n deasserted mid-word: partial word discarded, no we/re, addr/tx unchanged. o_core_rst_n is retained.
- SCLK edges while en_n is high are ignored.
- Asynchronous reset mid-frame: immediate return to reset values.
- imem and dmem strobes are never active simultaneously.

Test Plan:
- Power-up: o_core_rst_n=0. Frame 0x06 -> o_core_rst_n=1 within 4 cycles after the 8th SCLK rise. Frame 0x05 -> back to 0.
- IMEM write burst: cmd 0x01, addr 0x01FE, data 0x000A, 0x0005, 0x0003 -> three we pulses with (addr, wdata) = (0x1FE, 0xA), (0x1FF, 0x5), (0x000, 0x3). Checks wrap-around.
- DMEM read: cmd 0x04, addr 0x0007, memory returns 0x1A5 then 0x0FF -> MISO shifts 0x01A5 then 0x00FF. re pulses at addr 7 and 8.
- Abort: cmd 0x03, addr 0x0002, 9 data bits, en_n high -> no o_dmem_we. The next frame decodes normally.
- Unknown cmd 0x7E followed by 32 SCLKs -> no strobes, MISO stays 0, o_core_rst_n unchanged.
- Async reset asserted mid-DATA -> all outputs 0 immediately. After release, a new frame is accepted from IDLE.
